dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Responder for the processor's data-memory port: serves address_dmem / data / wren and returns q_dmem.
- Low addresses map to a word-addressed RAM.
- A small MMIO window at the top of the address space exposes three registers:
  - a free-running cycle counter;
  - a transmit FIFO that drains to an external consumer over a valid/ready handshake;
  - a status register.
- Sits in the wrapper between the processor and the backing data memory.

Parameters:
DEPTH, 4096, number of 32-bit RAM words
ADDR_W, 12, RAM index width (log2 DEPTH)
MMIO_BASE, 32'hFFFF_FF00, first MMIO word address (word-addressed, same units as address_dmem)
FIFO_DEPTH, 4, TX FIFO entries (power of two, at least 2)

Ports:
clock  in  1  master clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset; state clears on a rising edge with reset==0
address_dmem  in  32  word address from processor
data  in  32  store data from processor
wren  in  1  store enable, single cycle per store
q_dmem  out  32  read data, combinational from address_dmem
tx_data  out  32  FIFO head word
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts head when tx_valid and tx_ready both high at a rising edge

Behaviour:
- Address decode:
  - RAM when address_dmem < DEPTH.
  - MMIO when address_dmem is MMIO_BASE+0, +1 or +2.
  - Every other address is unmapped.
- Reads are combinational, so q_dmem is valid in the same cycle as address_dmem. The processor latches q_dmem at the end of its memory stage.
- Writes take effect at the rising edge where wren==1. A read of the same address in the next cycle returns the new value.
- RAM:
  - Asynchronous read; write on the clock edge.
  - Contents are not cleared by reset.
- Unmapped addresses: reads return 0; writes are ignored with no side effects.
- MMIO+0, CYCLES:
  - 32-bit counter, reset value 0, increments by 1 every cycle and wraps from FFFF_FFFF to 0.
  - A write loads data; the next cycle's value is data, and increments resume after that.
- MMIO+1, TXDATA:
  - A write pushes data into the FIFO.
  - A read returns the head word, or 0 when the FIFO is empty. Reads do not pop.
- MMIO+2, STATUS, read:
  - bit0 = full, bit1 = empty, bits[5:2] = occupancy count (0..FIFO_DEPTH), bit6 = sticky overflow, other bits 0.
  - A write with data[6]==1 clears the overflow bit. All other bits of the write are ignored.
- FIFO:
  - Circular buffer with head/tail pointers that wrap modulo FIFO_DEPTH, plus a count register.
  - Pop occurs when tx_valid && tx_ready at a rising edge.
  - Push is accepted when not full, or when full and a pop occurs in the same cycle (count unchanged, tail advances).
  - A push to a full FIFO with no simultaneous pop is dropped and sets overflow=1; the stored data is unchanged.
  - Simultaneous push and pop on an empty FIFO: no pop happens because tx_valid==0, and the push is accepted.
  - No bypass: the first pushed word appears on tx_data and raises tx_valid one cycle after the push edge.
  - tx_data is undefined-stable (holds the last slot contents) when tx_valid==0; the consumer must ignore it.
- Reset (reset==0 at an edge):
  - Counter=0, FIFO pointers and count=0, overflow=0.
  - tx_valid=0, tx_data=0 after reset (slots are cleared).
  - Reset mid-transfer discards all queued words.
  - Reset has priority over a simultaneous write or pop.
- When reset==0, q_dmem still reflects RAM and MMIO combinationally.

Test Plan:
- RAM round trip: write 32'hDEADBEEF to address 5 with wren=1 for 1 cycle, then read address 5 -> q_dmem=32'hDEADBEEF same cycle; read address DEPTH -> 0.
- Counter: release reset, read MMIO+0 on the 10th cycle after release -> 9 (first post-reset cycle reads 0); write 32'hFFFF_FFFE, then -> FFFF_FFFE, FFFF_FFFF, 0 on successive cycles.
- FIFO fill/drain with tx_ready=0: push 1,2,3,4 -> STATUS=0x11 (count 4, full); 5th push 5 -> STATUS bit6=1, count 4; raise tx_ready -> tx_data sequence 1,2,3,4, then tx_valid=0 and STATUS=0x42; write STATUS with data=0x40 -> STATUS=0x02.
- Full + simultaneous push/pop: FIFO full with 1..4, tx_ready=1 and push 9 in the same cycle -> count stays 4, overflow stays 0, output order 2,3,4,9.
- Reset mid-operation: FIFO holding 2 words, counter at 100, assert reset=0 for one edge -> tx_valid=0, STATUS=0x02, CYCLES reads 0; RAM address 5 still holds DEADBEEF.
- Unmapped write: write 7 to MMIO_BASE+3 -> no state change; reading it returns 0.

Source files
------------

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory port bundle between the processor and the responder,
// plus the TX FIFO valid/ready handshake toward the external consumer.
interface dmem_mmio_responder_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output address_dmem, data, wren, tx_ready,
        input  q_dmem, tx_data, tx_valid
    );

    modport slave (
        input  address_dmem, data, wren, tx_ready,
        output q_dmem, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM at the bottom of the address space and an
// MMIO window (cycle counter, TX FIFO, status) at MMIO_BASE. Reads are combinational.
module dmem_mmio_responder #(
    parameter int          DEPTH      = 4096,
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    dmem_mmio_responder_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              ram_sel;
    logic              cyc_sel;
    logic              txd_sel;
    logic              stat_sel;
    logic [ADDR_W-1:0] ram_idx;

    assign ram_sel  = bus.address_dmem < 32'(DEPTH);
    assign cyc_sel  = bus.address_dmem == MMIO_BASE;
    assign txd_sel  = bus.address_dmem == MMIO_BASE + 32'd1;
    assign stat_sel = bus.address_dmem == MMIO_BASE + 32'd2;
    assign ram_idx  = bus.address_dmem[ADDR_W-1:0];

    logic [31:0]      ram [DEPTH];
    logic [31:0]      cycles_reg;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;
    logic [31:0]      slot_word [FIFO_DEPTH];

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic accept;

    assign full   = count_reg == CNT_W'(FIFO_DEPTH);
    assign empty  = count_reg == '0;
    assign pop    = !empty && bus.tx_ready;
    assign push   = bus.wren && txd_sel;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign accept = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (bus.wren && ram_sel) begin
            ram[ram_idx] <= bus.data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycles_reg <= '0;
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            cycles_reg <= (bus.wren && cyc_sel) ? bus.data : cycles_reg + 32'd1;
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (accept) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (push && full && !pop) begin
                ovf_reg <= 1'b1;
            end else if (bus.wren && stat_sel && bus.data[6]) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // Each slot is its own register so reset can clear it alongside the pointers.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        logic [31:0] slot_reg;

        always_ff @(posedge clock) begin
            if (!reset) begin
                slot_reg <= '0;
            end else if (accept && tail_reg == PTR_W'(gi)) begin
                slot_reg <= bus.data;
            end
        end

        assign slot_word[gi] = slot_reg;
    end

    logic [31:0] status_word;
    assign status_word = {25'd0, ovf_reg, 4'(count_reg), empty, full};

    assign bus.tx_data  = slot_word[head_reg];
    assign bus.tx_valid = !empty;

    always_comb begin
        bus.q_dmem = '0;
        if (ram_sel) begin
            bus.q_dmem = ram[ram_idx];
        end else if (cyc_sel) begin
            bus.q_dmem = cycles_reg;
        end else if (txd_sel) begin
            bus.q_dmem = empty ? 32'd0 : slot_word[head_reg];
        end else if (stat_sel) begin
            bus.q_dmem = status_word;
        end
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_dmem_mmio_responder;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] MB    = 32'hFFFF_FF00;
    localparam int          FD    = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .DEPTH(DEPTH), .ADDR_W(12), .MMIO_BASE(MB), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: RAM contents seen so far, counter, FIFO as a queue, sticky overflow.
    logic [31:0] ram_m [logic [31:0]];
    logic [31:0] cyc_m = '0;
    logic [31:0] fifo_m [$];
    logic        ovf_m = 1'b0;
    bit          model_on = 1'b0;

    function automatic logic [31:0] status_m();
        return {25'd0, ovf_m, 4'(fifo_m.size()), fifo_m.size() == 0, fifo_m.size() == FD};
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            cyc_m = '0;
            fifo_m.delete();
            ovf_m = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (bus.wren && bus.address_dmem == MB) cyc_m = bus.data;
            else cyc_m = cyc_m + 32'd1;
            if (fifo_m.size() != 0 && bus.tx_ready) void'(fifo_m.pop_front());
            if (bus.wren && bus.address_dmem == MB + 32'd1) begin
                if (fifo_m.size() < FD) fifo_m.push_back(bus.data);
                else ovf_m = 1'b1;
            end
            if (bus.wren && bus.address_dmem == MB + 32'd2 && bus.data[6]) ovf_m = 1'b0;
        end
        if (bus.wren && bus.address_dmem < 32'(DEPTH)) ram_m[bus.address_dmem] = bus.data;
    end

    always @(negedge clock) begin
        if (model_on) begin
            logic [31:0] exp_q;
            bit          known;
            known = 1'b1;
            exp_q = '0;
            if (bus.address_dmem < 32'(DEPTH)) begin
                known = ram_m.exists(bus.address_dmem);
                if (known) exp_q = ram_m[bus.address_dmem];
            end else if (bus.address_dmem == MB) begin
                exp_q = cyc_m;
            end else if (bus.address_dmem == MB + 32'd1) begin
                exp_q = (fifo_m.size() != 0) ? fifo_m[0] : 32'd0;
            end else if (bus.address_dmem == MB + 32'd2) begin
                exp_q = status_m();
            end
            check("model_tx_valid", {31'd0, bus.tx_valid}, {31'd0, fifo_m.size() != 0});
            if (fifo_m.size() != 0) check("model_tx_data", bus.tx_data, fifo_m[0]);
            if (known) check("model_q_dmem", bus.q_dmem, exp_q);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.address_dmem = a;
        bus.data         = d;
        bus.wren         = 1'b1;
        tick();
        bus.wren = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        bus.address_dmem = a;
        #2;
        check(nm, bus.q_dmem, exp);
    endtask

    initial begin
        logic [31:0] swap_order [4];
        swap_order = '{32'd2, 32'd3, 32'd4, 32'd9};
        bus.address_dmem = '0;
        bus.data         = '0;
        bus.wren         = 1'b0;
        bus.tx_ready     = 1'b0;

        tick();
        tick();
        reset = 1'b1;

        // Counter after reset release, then load and wrap
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_tx_data", bus.tx_data, 32'd0);
        rd("cyc_first", MB, 32'd0);
        for (int k = 0; k < 9; k++) tick();
        rd("cyc_tenth", MB, 32'd9);
        wr(MB, 32'hFFFF_FFFE);
        rd("cyc_load", MB, 32'hFFFF_FFFE);
        tick();
        rd("cyc_max", MB, 32'hFFFF_FFFF);
        tick();
        rd("cyc_wrap", MB, 32'd0);
        rd("stat_idle", MB + 32'd2, 32'h02);

        // RAM round trip and out-of-range read
        wr(32'd5, 32'hDEAD_BEEF);
        rd("ram5", 32'd5, 32'hDEAD_BEEF);
        rd("ram_oob", 32'(DEPTH), 32'd0);
        tick();

        // FIFO fill, overflow, drain
        for (int i = 1; i <= 4; i++) wr(MB + 32'd1, 32'(i));
        rd("stat_full", MB + 32'd2, 32'h11);
        rd("txd_head", MB + 32'd1, 32'd1);
        tick();
        wr(MB + 32'd1, 32'd5);
        rd("stat_ovf", MB + 32'd2, 32'h51);
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", {31'd0, bus.tx_valid}, 32'd1);
            check("drain_data", bus.tx_data, 32'(i));
            tick();
        end
        check("drained_valid", {31'd0, bus.tx_valid}, 32'd0);
        rd("stat_drained", MB + 32'd2, 32'h42);
        bus.tx_ready = 1'b0;
        wr(MB + 32'd2, 32'h40);
        rd("stat_cleared", MB + 32'd2, 32'h02);
        rd("txd_empty", MB + 32'd1, 32'd0);
        tick();

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 4; i++) wr(MB + 32'd1, 32'(i));
        bus.tx_ready = 1'b1;
        wr(MB + 32'd1, 32'd9);
        bus.tx_ready = 1'b0;
        rd("stat_swap", MB + 32'd2, 32'h11);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("swap_data", bus.tx_data, swap_order[i]);
            tick();
        end
        bus.tx_ready = 1'b0;
        check("swap_empty", {31'd0, bus.tx_valid}, 32'd0);

        // Reset with two queued words and counter at 100
        wr(MB + 32'd1, 32'h77);
        wr(MB + 32'd1, 32'h88);
        wr(MB, 32'd100);
        rd("cyc_100", MB, 32'd100);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("mid_rst_txdata", bus.tx_data, 32'd0);
        rd("mid_rst_cyc", MB, 32'd0);
        rd("mid_rst_stat", MB + 32'd2, 32'h02);
        tick();
        rd("mid_rst_ram5", 32'd5, 32'hDEAD_BEEF);

        // Unmapped write has no side effects
        wr(MB + 32'd3, 32'd7);
        rd("unmapped", MB + 32'd3, 32'd0);
        rd("unm_stat", MB + 32'd2, 32'h02);
        tick();
        rd("unm_ram5", 32'd5, 32'hDEAD_BEEF);
        bus.address_dmem = MB;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
